mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter and sequencer for the 256 x 8 single-port memory (start/write/addr/data interface). Two requesters issue independent read or write transactions. The block grants one at a time, drives a one-cycle start pulse with the latched command to the memory, waits a fixed memory latency, and returns read data plus a done pulse to the winner. It sits between the bus-side requesters and the memory instance.

## Interface
- ADDR_W, 8, memory address width (256 locations)
- DATA_W, 8, memory data width
- MEM_LAT, 1, cycles from mem_start high until mem_rdata valid; legal range 1..15
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req[1:0]  in  2  per-requester transaction request, level
- we[1:0]  in  2  per-requester write enable (1 = write, 0 = read)
- addr0, addr1  in  ADDR_W  per-requester address
- wdata0, wdata1  in  DATA_W  per-requester write data
- gnt[1:0]  out  2  one-hot grant pulse, 1 cycle
- done[1:0]  out  2  one-hot completion pulse, 1 cycle
- rdata  out  DATA_W  read data, valid while done is high; holds its value otherwise
- mem_start  out  1  start pulse to the memory, 1 cycle
- mem_write  out  1  write qualifier, valid with mem_start
- mem_addr  out  ADDR_W  memory address, valid with mem_start
- mem_wdata  out  DATA_W  memory write data, valid with mem_start
- mem_rdata  in  DATA_W  memory read-back, sampled MEM_LAT cycles after mem_start

## Operation
- The FSM has four states. IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - if req != 0, pick the winner, latch its we/addr/wdata, and go to ISSUE.
  - otherwise stay in IDLE.
- Winner selection is round-robin:
  - if only one req is high, that requester wins;
  - if both are high, the requester not served last wins;
  - the pointer resets to "requester 0 wins first".
- ISSUE: gnt[w]=1, mem_start=1, mem_write/mem_addr/mem_wdata = latched command. Go to WAIT with the latency counter = MEM_LAT-1.
- WAIT: decrement the counter each cycle. At 0, capture mem_rdata into rdata and go to DONE.
- DONE: done[w]=1. The last-served pointer is updated to w. Go to IDLE.
- Writes also capture mem_rdata. rdata on a write done is therefore the written value, because the memory displays/returns mem[addr] after the write.
- Requesters hold req and the command stable from assertion until done. req still high in the cycle after done counts as a new request.
- Command inputs are sampled only in IDLE. Changes after grant are ignored.
- Reset (rst_n=0 at a clock edge), from any state:
  - state=IDLE, pointer=0;
  - gnt, done, mem_start, mem_write = 0; mem_addr, mem_wdata, rdata = 0.
  - An in-flight transaction is aborted with no done pulse. A start already issued is not retracted.

## Timing
- Edge N samples req in IDLE.
- Cycle N+1: gnt and mem_start high (ISSUE).
- Cycles N+2 .. N+1+MEM_LAT: WAIT.
- Cycle N+2+MEM_LAT: done high, rdata valid.
- Edge at end of the DONE cycle returns to IDLE. Next sample is at edge N+3+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles. With MEM_LAT=1: done 3 cycles after the sample edge, 4-cycle period.
- mem_start is never high in two consecutive cycles. gnt and mem_start are always coincident. At most one bit of gnt/done is set at a time.
- Simultaneous req rising in IDLE: exactly one grant. The loser waits, then wins the next arbitration.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=2'b11 -> all outputs 0, no gnt. First grant after release goes to requester 0.
- Single write then read:
  - req0 write addr=8'h10, wdata=8'hA5 -> gnt=01 and mem_start with addr 10/write 1 one cycle after sample; done=01 at MEM_LAT+2.
  - then req0 read addr=8'h10 -> rdata=8'hA5 with done.
- Contention: both req high continuously, req0 write 8'h3C @8'h20, req1 write 8'hC3 @8'h21 -> grants alternate 0,1,0,1, never two gnt bits set, 4-cycle spacing at MEM_LAT=1.
- Latency parameter: MEM_LAT=4, read of preloaded 8'h7E -> done exactly 6 cycles after the sample edge, rdata=8'h7E.
- Reset mid-operation: assert rst_n=0 in WAIT -> next cycle IDLE, no done pulse. A pending req1 is granted after release when it is the only request.
- Stability: change addr0 from 8'h05 to 8'hFF in the ISSUE cycle -> mem_addr remains 8'h05 for that transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port memory.
// One transaction in flight at a time: grant + start pulse, fixed-latency wait,
// then read-back capture and a done pulse to the winner. All outputs registered.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_start,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              win_q, win_d;     // requester owning the current transaction
    logic              prio_q, prio_d;   // requester favoured when both request
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              start_q, start_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick;

    // Next-state and registered-output computation for the transaction sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        prio_d  = prio_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        rdata_d = rdata_q;
        start_d = 1'b0;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // Lone requester wins outright; on a tie the pointer decides.
        pick    = (req == 2'b11) ? prio_q : req[1];
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    win_d   = pick;
                    write_d = we[pick];
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Writes capture too: the memory returns the freshly written value.
                    rdata_d = mem_rdata;
                    done_d  = win_q ? 2'b10 : 2'b01;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                prio_d  = ~win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            prio_q  <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rdata_q <= '0;
            start_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_start = start_q;
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
